// File: rtl/controle_execucao.sv
`default_nettype none
// ============================================================================
// Module   : controle_execucao
// Purpose  : Execution sequencer for the multicycle processor. Drives the
//            processor's run / resetn inputs and offers continuous run,
//            single-step and halt modes plus one PC breakpoint. Instruction
//            boundaries are found from the processor's done strobe; the PC
//            (R7_out) is inspected in a one-cycle CHECK bubble after each
//            instruction retires in continuous mode.
// Ports    : clock, reset         - clock (rising edge) and async reset (high)
//            start, step, halt    - one-cycle control pulses
//            clear_cpu            - one-cycle pulse, re-reset the processor
//            bp_en, bp_addr[15:0] - breakpoint enable and PC value
//            pc[15:0], done       - processor PC and end-of-instruction strobe
//            run, proc_resetn     - processor run and active-low reset
//            state[2:0], busy     - FSM state code, not-IDLE flag
//            bp_hit               - sticky breakpoint-stop flag
//            instr_count          - retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module controle_execucao #(
  parameter int RESET_CYCLES = 2,
  parameter int COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic               halt,
  input  logic               clear_cpu,
  input  logic               bp_en,
  input  logic [15:0]        bp_addr,
  input  logic [15:0]        pc,
  input  logic               done,
  output logic               run,
  output logic               proc_resetn,
  output logic [2:0]         state,
  output logic               busy,
  output logic               bp_hit,
  output logic [COUNT_W-1:0] instr_count
);

  // Width of the processor-reset down-counter; at least one bit so that
  // RESET_CYCLES == 1 still yields a legal vector.
  localparam int c_cnt_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  // Loading RESET_CYCLES-1 and leaving on zero keeps RSTP for exactly
  // RESET_CYCLES cycles.
  localparam logic [c_cnt_w-1:0] c_rst_load = c_cnt_w'(RESET_CYCLES - 1);
  localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

  typedef enum logic [2:0] {
    ST_RSTP  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_rst_cnt;
  logic [c_cnt_w-1:0]   w_rst_cnt_next;
  logic                 r_halt_pending;
  logic                 w_halt_pending_next;
  logic                 r_bp_hit;
  logic                 w_bp_hit_next;
  logic [COUNT_W-1:0]   r_instr_count;
  logic [COUNT_W-1:0]   w_instr_count_next;
  logic                 w_bp_match;

  assign w_bp_match = bp_en && (pc == bp_addr);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_RSTP;
      r_rst_cnt      <= c_rst_load;
      r_halt_pending <= 1'b0;
      r_bp_hit       <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_rst_cnt      <= w_rst_cnt_next;
      r_halt_pending <= w_halt_pending_next;
      r_bp_hit       <= w_bp_hit_next;
      r_instr_count  <= w_instr_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and register-update logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next        = r_state;
    w_rst_cnt_next      = r_rst_cnt;
    w_halt_pending_next = r_halt_pending;
    w_bp_hit_next       = r_bp_hit;
    w_instr_count_next  = r_instr_count;

    if (clear_cpu) begin
      // Clearing the CPU overrides everything, including a done that lands
      // on the same edge: the aborted instruction is never counted.
      w_state_next        = ST_RSTP;
      w_rst_cnt_next      = c_rst_load;
      w_halt_pending_next = 1'b0;
      w_bp_hit_next       = 1'b0;
      w_instr_count_next  = '0;
    end else begin
      unique case (r_state)
        ST_RSTP: begin
          w_halt_pending_next = 1'b0;
          if (r_rst_cnt == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_rst_cnt_next = r_rst_cnt - 1'b1;
          end
        end

        ST_IDLE: begin
          // halt is meaningless while stopped, so it is not latched here.
          w_halt_pending_next = 1'b0;
          if (start) begin
            w_state_next  = ST_RUN;
            w_bp_hit_next = 1'b0;
          end else if (step) begin
            w_state_next  = ST_STEP;
            w_bp_hit_next = 1'b0;
          end
        end

        ST_RUN: begin
          if (halt) begin
            w_halt_pending_next = 1'b1;
          end
          if (done) begin
            w_state_next       = ST_CHECK;
            w_instr_count_next = r_instr_count + c_count_one;
          end
        end

        ST_CHECK: begin
          // The processor sits between instructions here with pc already
          // pointing at the next one (also after a jump), so this is the
          // only safe place to stop or to compare against the breakpoint.
          if (r_halt_pending || halt) begin
            w_state_next        = ST_IDLE;
            w_halt_pending_next = 1'b0;
          end else if (w_bp_match) begin
            w_state_next        = ST_IDLE;
            w_halt_pending_next = 1'b0;
            w_bp_hit_next       = 1'b1;
          end else begin
            w_state_next = ST_RUN;
          end
        end

        ST_STEP: begin
          // Single step runs one instruction regardless of breakpoint/halt.
          if (done) begin
            w_state_next        = ST_IDLE;
            w_halt_pending_next = 1'b0;
            w_instr_count_next  = r_instr_count + c_count_one;
          end
        end

        default: begin
          w_state_next        = ST_RSTP;
          w_rst_cnt_next      = c_rst_load;
          w_halt_pending_next = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs, decoded from the state register only
  // --------------------------------------------------------------------------
  assign run         = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign proc_resetn = (r_state != ST_RSTP);
  assign busy        = (r_state != ST_IDLE);
  assign state       = r_state;
  assign bp_hit      = r_bp_hit;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_controle_execucao.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_execucao
// Purpose  : Self-checking bench for controle_execucao. A small processor
//            model executes a looping program with randomized instruction
//            lengths; expected counts, cycle totals and stop addresses are
//            derived from the program table and the sequencer's rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_execucao;

  localparam int RESET_CYCLES = 2;
  localparam int CW           = 4;   // narrow counter so wrap-around is reachable
  localparam int BOUND        = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          halt = 1'b0;
  logic          clear_cpu = 1'b0;
  logic          bp_en = 1'b0;
  logic [15:0]   bp_addr = 16'h0000;
  logic [15:0]   pc = 16'h0000;
  logic          done = 1'b0;
  logic          run;
  logic          proc_resetn;
  logic [2:0]    state;
  logic          busy;
  logic          bp_hit;
  logic [CW-1:0] instr_count;

  controle_execucao #(
    .RESET_CYCLES(RESET_CYCLES),
    .COUNT_W     (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .step       (step),
    .halt       (halt),
    .clear_cpu  (clear_cpu),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .done       (done),
    .run        (run),
    .proc_resetn(proc_resetn),
    .state      (state),
    .busy       (busy),
    .bp_hit     (bp_hit),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Program: 0 mvi(4) -> 2 -> 3 -> 4 -> 6 -> 7 (jump) -> 0
  int len [0:7];
  int nxt [0:7];

  // Processor model state and reference tallies
  int   p_pc      = 0;
  int   pcnt      = 0;
  int   exp_count = 0;
  int   ret_total = 0;
  logic spur      = 1'b0;
  logic run_q     = 1'b0;
  logic rn_q      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DUT outputs captured mid-cycle, used at the following rising edge.
  initial forever begin
    @(negedge clock);
    run_q = run;
    rn_q  = proc_resetn;
  end

  // Processor: advances its step counter while run is high, asserts done on
  // the last step, moves pc on the retiring edge; resetn low resets it.
  initial forever begin
    @(posedge clock);
    if (reset || clear_cpu) begin
      exp_count = 0;
    end else if (run_q && done) begin
      exp_count = (exp_count + 1) % (1 << CW);
      ret_total++;
    end
    if (reset || !rn_q) begin
      p_pc = 0;
      pcnt = 0;
    end else if (run_q) begin
      if (done) begin
        p_pc = nxt[p_pc];
        pcnt = 0;
      end else begin
        pcnt++;
      end
    end
    #1;
    done = (run && proc_resetn && (pcnt == len[p_pc] - 1)) || spur;
    pc   = 16'(p_pc);
  end

  task automatic wait_idle(output int cyc, output int runc);
    cyc  = 0;
    runc = 0;
    while (busy === 1'b1 && cyc < BOUND) begin
      cyc++;
      if (run === 1'b1) runc++;
      @(negedge clock);
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic count_rstp(output int n);
    n = 0;
    while (proc_resetn !== 1'b1 && n < 50) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      k++;
      @(negedge clock);
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_step(output int cyc, output int runc);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    wait_idle(cyc, runc);
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
  endtask

  // Instructions and cycles from p until the processor next sits at b.
  task automatic walk(input int p, input int b, output int n, output int s);
    n = 0;
    s = 0;
    do begin
      s += len[p];
      n++;
      p = nxt[p];
    end while (p != b && n < 100);
  endtask

  initial begin
    int cyc, runc, n, s, p0, r_at, o;

    for (int i = 0; i < 8; i++) begin
      len[i] = 3 + int'($urandom_range(0, 3));
      nxt[i] = 0;
    end
    len[0] = 4;
    nxt[0] = 2; nxt[2] = 3; nxt[3] = 4; nxt[4] = 6; nxt[6] = 7; nxt[7] = 0;

    // ---- asynchronous reset ------------------------------------------------
    #3 reset = 1'b1;
    #1;
    check("rst_state",  {29'd0, state}, 32'd0);
    check("rst_run",    {31'd0, run}, 32'd0);
    check("rst_resetn", {31'd0, proc_resetn}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd1);
    check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("rst_count",  {28'd0, instr_count}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    count_rstp(n);
    check("rstp_len", n, RESET_CYCLES);
    check("post_rst_state", {29'd0, state}, 32'd1);
    check("post_rst_busy",  {31'd0, busy}, 32'd0);

    // ---- single step of the 4-cycle mvi -------------------------------------
    p0 = p_pc;
    do_step(cyc, runc);
    check("step_busy_cycles", cyc, len[p0]);
    check("step_run_cycles",  runc, len[p0]);
    check("step_count", {28'd0, instr_count}, 32'd1);
    check("step_pc", {16'd0, pc}, 32'h2);
    check("step_state", {29'd0, state}, 32'd1);

    // ---- breakpoint at 0x0006 ------------------------------------------------
    bp_en   = 1'b1;
    bp_addr = 16'h0006;
    walk(p_pc, 6, n, s);
    pulse_start();
    wait_idle(cyc, runc);
    check("bp1_cycles", cyc, s + n);
    check("bp1_run_cycles", runc, s);
    check("bp1_hit", {31'd0, bp_hit}, 32'd1);
    check("bp1_pc", {16'd0, pc}, 32'h6);
    check("bp1_count", {28'd0, instr_count}, exp_count);

    // resume on the breakpoint address: one full loop before the next stop
    walk(6, 6, n, s);
    pulse_start();
    check("resume_bp_clear", {31'd0, bp_hit}, 32'd0);
    check("resume_state", {29'd0, state}, 32'd2);
    wait_idle(cyc, runc);
    check("bp2_instrs", n, 6);
    check("bp2_cycles", cyc, s + n);
    check("bp2_hit", {31'd0, bp_hit}, 32'd1);
    check("bp2_pc", {16'd0, pc}, 32'h6);
    check("bp2_count", {28'd0, instr_count}, exp_count);

    // step on the breakpoint address ignores it and clears bp_hit
    do_step(cyc, runc);
    check("step_bp_cycles", cyc, len[6]);
    check("step_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("step_bp_pc", {16'd0, pc}, 32'h7);

    // stop on the breakpoint again, then clear_cpu from IDLE
    pulse_start();
    wait_idle(cyc, runc);
    check("bp3_hit", {31'd0, bp_hit}, 32'd1);
    clear_cpu = 1'b1;
    @(negedge clock);
    clear_cpu = 1'b0;
    check("clr_idle_state", {29'd0, state}, 32'd0);
    check("clr_idle_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("clr_idle_count", {28'd0, instr_count}, 32'd0);
    count_rstp(n);
    check("clr_rstp_len", n, RESET_CYCLES);
    bp_en = 1'b0;

    // ---- halt and done in IDLE are ignored ---------------------------------
    halt = 1'b1;
    spur = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    spur = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_ignore_state", {29'd0, state}, 32'd1);
    check("idle_ignore_count", {28'd0, instr_count}, exp_count);
    r_at = ret_total;
    pulse_start();
    o = 0;
    while (ret_total < r_at + 2 && o < BOUND) begin
      o++;
      @(negedge clock);
    end
    check("halt_not_latched", {31'd0, ret_total >= r_at + 2}, 32'd1);

    // ---- halt coincident with done -----------------------------------------
    wait_done();
    r_at = ret_total;
    p0   = p_pc;
    pulse_halt();
    check("coinc_check_state", {29'd0, state}, 32'd3);
    check("coinc_check_run", {31'd0, run}, 32'd0);
    wait_idle(cyc, runc);
    check("coinc_retired", ret_total, r_at + 1);
    check("coinc_pc", {16'd0, pc}, nxt[p0]);
    check("coinc_count", {28'd0, instr_count}, exp_count);

    // ---- halt mid-instruction ----------------------------------------------
    pulse_start();
    wait_done();
    repeat (2) @(negedge clock);
    p0   = p_pc;
    r_at = ret_total;
    o    = int'($urandom_range(0, len[p0] - 2));
    repeat (o) @(negedge clock);
    pulse_halt();
    wait_idle(cyc, runc);
    check("mid_retired", ret_total, r_at + 1);
    check("mid_pc", {16'd0, pc}, nxt[p0]);
    check("mid_count", {28'd0, instr_count}, exp_count);

    // ---- halt during the CHECK bubble ---------------------------------------
    pulse_start();
    wait_done();
    @(negedge clock);
    r_at = ret_total;
    pulse_halt();
    check("chk_halt_state", {29'd0, state}, 32'd1);
    check("chk_halt_retired", ret_total, r_at);

    // ---- start and step together: start wins --------------------------------
    start = 1'b1;
    step  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    step  = 1'b0;
    check("both_state", {29'd0, state}, 32'd2);
    check("both_run", {31'd0, run}, 32'd1);
    pulse_halt();
    wait_idle(cyc, runc);

    // ---- clear_cpu during RUN with count 5 ----------------------------------
    clear_cpu = 1'b1;
    @(negedge clock);
    clear_cpu = 1'b0;
    count_rstp(n);
    for (int i = 0; i < 5; i++) do_step(cyc, runc);
    check("five_count", {28'd0, instr_count}, 32'd5);
    pulse_start();
    @(negedge clock);
    r_at = ret_total;
    clear_cpu = 1'b1;
    @(negedge clock);
    clear_cpu = 1'b0;
    check("clr_run_state", {29'd0, state}, 32'd0);
    check("clr_run_run", {31'd0, run}, 32'd0);
    check("clr_run_resetn", {31'd0, proc_resetn}, 32'd0);
    check("clr_run_count", {28'd0, instr_count}, 32'd0);
    check("clr_run_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("clr_run_no_retire", ret_total, r_at);
    count_rstp(n);
    check("clr_run_rstp_len", n, RESET_CYCLES);

    // ---- counter wrap (2^CW retirements return to zero) ----------------------
    for (int i = 1; i <= (1 << CW) + 1; i++) begin
      do_step(cyc, runc);
      check("wrap_count", {28'd0, instr_count}, exp_count);
      if (i == (1 << CW)) check("wrap_zero", {28'd0, instr_count}, 32'd0);
    end

    // ---- asynchronous reset mid-instruction ---------------------------------
    pulse_start();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("amid_run", {31'd0, run}, 32'd0);
    check("amid_resetn", {31'd0, proc_resetn}, 32'd0);
    check("amid_count", {28'd0, instr_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_rstp(n);
    check("amid_rstp_len", n, RESET_CYCLES);
    check("amid_state", {29'd0, state}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
